vram_ctrl: RTL and testbench

- Front-end controller for the text/video RAM: one synchronous read port, one write port, 1-cycle read latency.
- Shares the read port between video scanout (fixed priority, never stalls) and CPU readback.
- Shares the write port between CPU writes and a hardware clear/fill engine.
- Sits between the bus interface, the video timing generator and the RAM instance.

---
 rtl/vram_ctrl_if.sv | 42 ++++
 rtl/vram_ctrl.sv | 146 ++++++++++++++
 tb/tb_vram_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_ctrl_if.sv
// Bus bundle between vram_ctrl and its neighbours: video scanout, CPU bus and the RAM macro.
// The controller connects through the slave modport; the surrounding logic uses master.
interface vram_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  vid_req;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic                  vid_valid;
  logic [DATA_WIDTH-1:0] vid_data;
  logic                  cpu_rreq;
  logic [ADDR_WIDTH-1:0] cpu_raddr;
  logic                  cpu_rready;
  logic                  cpu_rvalid;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_wreq;
  logic [ADDR_WIDTH-1:0] cpu_waddr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_wready;
  logic                  clr_start;
  logic [DATA_WIDTH-1:0] clr_value;
  logic                  clr_busy;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_wen;

  modport slave (
    input  vid_req, vid_addr, cpu_rreq, cpu_raddr, cpu_wreq, cpu_waddr, cpu_wdata,
           clr_start, clr_value, ram_dout,
    output vid_valid, vid_data, cpu_rready, cpu_rvalid, cpu_rdata, cpu_wready,
           clr_busy, ram_raddr, ram_waddr, ram_din, ram_wen
  );

  modport master (
    output vid_req, vid_addr, cpu_rreq, cpu_raddr, cpu_wreq, cpu_waddr, cpu_wdata,
           clr_start, clr_value, ram_dout,
    input  vid_valid, vid_data, cpu_rready, cpu_rvalid, cpu_rdata, cpu_wready,
           clr_busy, ram_raddr, ram_waddr, ram_din, ram_wen
  );
endinterface

// File: rtl/vram_ctrl.sv
// Video RAM front end: video/CPU read arbitration, one-entry CPU write buffer and clear/fill engine.
// Optional macro VRAM_CTRL_RAW_BYPASS_EN forwards same-cycle write data to the read response.
module vram_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  vram_ctrl_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [DATA_WIDTH-1:0] clr_val_q;

  logic                  rpend_q, rpend_d;
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic                  vvld_q, cvld_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  wb_full_q, wb_full_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic [DATA_WIDTH-1:0] wb_data_q;

  logic                  cpu_issue, r_accept, drain, w_accept;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Video owns the read port whenever it asks; the CPU only issues in gaps.
  assign cpu_issue = rpend_q & ~bus.vid_req;
  assign r_accept  = bus.cpu_rreq & ~rpend_q;
  assign drain     = wb_full_q & (state_q == IDLE);
  assign w_accept  = bus.cpu_wreq & bus.cpu_wready;

  assign bus.ram_raddr  = bus.vid_req ? bus.vid_addr : raddr_q;
  assign bus.cpu_rready = ~rpend_q;
  assign bus.cpu_wready = ~wb_full_q | drain;
  assign bus.clr_busy   = (state_q == FILL);

  always_comb begin
    bus.ram_wen   = 1'b0;
    bus.ram_waddr = wb_addr_q;
    bus.ram_din   = wb_data_q;
    if (state_q == FILL) begin
      bus.ram_wen   = 1'b1;
      bus.ram_waddr = cnt_q;
      bus.ram_din   = clr_val_q;
    end else if (wb_full_q) begin
      bus.ram_wen   = 1'b1;
    end
  end

`ifdef VRAM_CTRL_RAW_BYPASS_EN
  logic                  fwd_q, fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data_q;

  assign fwd_hit  = bus.ram_wen & (bus.ram_waddr == bus.ram_raddr) & (bus.vid_req | rpend_q);
  assign rsp_data = fwd_q ? fwd_data_q : bus.ram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_q <= fwd_hit;
      if (fwd_hit) fwd_data_q <= bus.ram_din;
    end
  end
`else
  assign rsp_data = bus.ram_dout;
`endif

  // Response data comes straight from the RAM output register; cpu_rdata is held afterwards.
  assign bus.vid_valid  = vvld_q;
  assign bus.vid_data   = vvld_q ? rsp_data : '0;
  assign bus.cpu_rvalid = cvld_q;
  assign bus.cpu_rdata  = cvld_q ? rsp_data : rdata_q;

  always_comb begin
    rpend_d = rpend_q;
    if (r_accept)       rpend_d = 1'b1;
    else if (cpu_issue) rpend_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpend_q <= 1'b0;
      raddr_q <= '0;
      vvld_q  <= 1'b0;
      cvld_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      rpend_q <= rpend_d;
      vvld_q  <= bus.vid_req;
      cvld_q  <= cpu_issue;
      if (r_accept) raddr_q <= bus.cpu_raddr;
      if (cvld_q)   rdata_q <= rsp_data;
    end
  end

  always_comb begin
    wb_full_d = wb_full_q;
    if (w_accept)   wb_full_d = 1'b1;
    else if (drain) wb_full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_full_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      wb_full_q <= wb_full_d;
      if (w_accept) begin
        wb_addr_q <= bus.cpu_waddr;
        wb_data_q <= bus.cpu_wdata;
      end
    end
  end

  // The fill owns the write port for exactly 2^ADDR_WIDTH cycles; the counter wraps to end it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      clr_val_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.clr_start) begin
            clr_val_q <= bus.clr_value;
            cnt_q     <= '0;
            state_q   <= FILL;
          end
        end
        FILL: begin
          cnt_q <= cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          if (&cnt_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_ctrl.sv
// Directed + randomized bench for vram_ctrl with a behavioural RAM and a reference memory image.
module tb_vram_ctrl;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst_n;
  int   cyc_cnt = 0;
  int   n_chk = 0;
  int   n_err = 0;

  vram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // RAM macro: registered read, read-before-write on a same-address collision.
  logic [DW-1:0] ram [0:DEPTH-1] = '{default: 8'h00};
  always @(posedge clk) begin
    if (bus.ram_wen) ram[bus.ram_waddr] <= bus.ram_din;
    bus.ram_dout <= ram[bus.ram_raddr];
  end

  // Expected memory contents, updated from what each transaction is supposed to do.
  logic [DW-1:0] ref_mem [0:DEPTH-1] = '{default: 8'h00};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic sm();
    @(negedge clk);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit chk_drain);
    int n;
    n = 0;
    nc();
    while (!bus.cpu_wready && n < 100) begin
      nc();
      n++;
    end
    check("wr_ready", bus.cpu_wready, 1);
    bus.cpu_wreq  = 1'b1;
    bus.cpu_waddr = a;
    bus.cpu_wdata = d;
    nc();
    bus.cpu_wreq = 1'b0;
    if (chk_drain) begin
      sm();
      check("drain_wen", bus.ram_wen, 1);
      check("drain_addr", bus.ram_waddr, a);
      check("drain_data", bus.ram_din, d);
    end
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    int n;
    int t0;
    n = 0;
    nc();
    while (!bus.cpu_rready && n < 100) begin
      nc();
      n++;
    end
    bus.cpu_rreq  = 1'b1;
    bus.cpu_raddr = a;
    t0 = cyc_cnt;
    nc();
    bus.cpu_rreq = 1'b0;
    sm();
    check("rready_after_accept", bus.cpu_rready, 0);
    n = 0;
    while (!bus.cpu_rvalid && n < 100) begin
      nc();
      sm();
      n++;
    end
    check("rvalid_seen", bus.cpu_rvalid, 1);
    lat = cyc_cnt - t0;
    d = bus.cpu_rdata;
    nc();
    sm();
    check("rvalid_pulse", bus.cpu_rvalid, 0);
    check("rdata_hold", bus.cpu_rdata, d);
  endtask

  task automatic vid_read(input logic [AW-1:0] a);
    nc();
    bus.vid_req  = 1'b1;
    bus.vid_addr = a;
    nc();
    bus.vid_req = 1'b0;
    sm();
    check("vid_rd", {bus.vid_valid, bus.vid_data}, {1'b1, ref_mem[a]});
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] raw_exp;
    logic [AW-1:0] a;
    logic [AW-1:0] va [0:4];
    int lat;
    int busy;

    rst_n = 1'b0;
    bus.vid_req = 0; bus.vid_addr = '0;
    bus.cpu_rreq = 0; bus.cpu_raddr = '0;
    bus.cpu_wreq = 0; bus.cpu_waddr = '0; bus.cpu_wdata = '0;
    bus.clr_start = 0; bus.clr_value = '0;
    repeat (2) @(posedge clk);
    sm();
    check("rst_rready", bus.cpu_rready, 1);
    check("rst_wready", bus.cpu_wready, 1);
    check("rst_busy", bus.clr_busy, 0);
    check("rst_wen", bus.ram_wen, 0);
    check("rst_vvalid", bus.vid_valid, 0);
    check("rst_rvalid", bus.cpu_rvalid, 0);
    check("rst_rdata", bus.cpu_rdata, 0);
    rst_n = 1'b1;

    // Basic write then CPU readback latency
    cpu_write(12'h010, 8'hA5, 1'b1);
    ref_mem[12'h010] = 8'hA5;
    repeat (3) nc();
    cpu_read(12'h010, d, lat);
    check("rd_latency", lat, 2);
    check("rd_data", d, 8'hA5);

    // Write drain colliding with a video read of the same address
    nc();
    bus.cpu_wreq = 1'b1; bus.cpu_waddr = 12'h100; bus.cpu_wdata = 8'h3C;
    nc();
    bus.cpu_wreq = 1'b0;
    bus.vid_req = 1'b1; bus.vid_addr = 12'h100;
    sm();
    check("raw_wen", bus.ram_wen, 1);
    check("raw_waddr", bus.ram_waddr, 12'h100);
`ifdef VRAM_CTRL_RAW_BYPASS_EN
    raw_exp = 8'h3C;
`else
    raw_exp = ref_mem[12'h100];
`endif
    nc();
    bus.vid_req = 1'b0;
    sm();
    check("raw_vvalid", bus.vid_valid, 1);
    check("raw_vdata", bus.vid_data, raw_exp);
    ref_mem[12'h100] = 8'h3C;
    vid_read(12'h100);

    // Random mix of writes, CPU reads and video reads on a small address window
    for (int i = 0; i < 60; i++) begin
      a = AW'($urandom_range(0, 63));
      case ($urandom_range(0, 2))
        0: begin
          d = DW'($urandom);
          cpu_write(a, d, 1'b1);
          ref_mem[a] = d;
        end
        1: begin
          cpu_read(a, d, lat);
          check("rnd_cpu_lat", lat, 2);
          check("rnd_cpu_data", d, ref_mem[a]);
        end
        default: vid_read(a);
      endcase
    end

    // Video holds the port for 5 cycles while a CPU read waits
    for (int k = 0; k < 5; k++) va[k] = AW'($urandom_range(0, 63));
    nc();
    bus.cpu_rreq = 1'b1; bus.cpu_raddr = 12'h100;
    bus.vid_req = 1'b1; bus.vid_addr = va[0];
    for (int k = 1; k <= 5; k++) begin
      nc();
      bus.cpu_rreq = 1'b0;
      if (k < 5) bus.vid_addr = va[k];
      else bus.vid_req = 1'b0;
      sm();
      check("pri_vid", {bus.vid_valid, bus.vid_data}, {1'b1, ref_mem[va[k-1]]});
      check("pri_rready", bus.cpu_rready, 0);
      check("pri_rvalid_wait", bus.cpu_rvalid, 0);
    end
    nc();
    sm();
    check("pri_rvalid", bus.cpu_rvalid, 1);
    check("pri_rdata", bus.cpu_rdata, 8'h3C);

    // Full fill, with a CPU write buffered mid-fill and a second one refused
    nc();
    bus.clr_start = 1'b1; bus.clr_value = 8'h20;
    nc();
    bus.clr_start = 1'b0; bus.clr_value = 8'h99;
    busy = 0;
    for (int k = 0; k < 5000; k++) begin
      sm();
      if (!bus.clr_busy) break;
      if (busy == 10) begin
        check("fill_wready_empty", bus.cpu_wready, 1);
        bus.cpu_wreq = 1'b1; bus.cpu_waddr = 12'h055; bus.cpu_wdata = 8'h7E;
      end else if (busy == 11) begin
        check("fill_wready_full", bus.cpu_wready, 0);
        bus.cpu_waddr = 12'h056; bus.cpu_wdata = 8'h11;
      end else if (busy == 12) begin
        bus.cpu_wreq = 1'b0;
      end else if (busy == 50) begin
        bus.clr_start = 1'b1; bus.clr_value = 8'h44;
      end else if (busy == 51) begin
        bus.clr_start = 1'b0;
      end
      if (busy == 100) begin
        check("fill_wen", bus.ram_wen, 1);
        check("fill_waddr", bus.ram_waddr, 100);
        check("fill_din", bus.ram_din, 8'h20);
      end
      busy++;
      nc();
    end
    check("fill_busy_cycles", busy, DEPTH);
    check("post_fill_drain_wen", bus.ram_wen, 1);
    check("post_fill_drain_addr", bus.ram_waddr, 12'h055);
    check("post_fill_drain_data", bus.ram_din, 8'h7E);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h20;
    ref_mem[12'h055] = 8'h7E;

    // Scan the whole memory through the video port
    for (int i = 0; i <= DEPTH; i++) begin
      nc();
      if (i < DEPTH) begin
        bus.vid_req = 1'b1; bus.vid_addr = AW'(i);
      end else begin
        bus.vid_req = 1'b0;
      end
      sm();
      if (i > 0) check("scan", {bus.vid_valid, bus.vid_data}, {1'b1, ref_mem[i-1]});
    end
    cpu_read(12'h055, d, lat);
    check("fill_cpu_055", d, 8'h7E);
    cpu_read(12'h056, d, lat);
    check("fill_cpu_056", d, 8'h20);

    // Reset in the middle of a fill
    nc();
    bus.clr_start = 1'b1; bus.clr_value = 8'h5A;
    nc();
    bus.clr_start = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      sm();
      if (bus.ram_waddr == 12'h123) break;
      nc();
    end
    check("abort_cnt_reached", bus.ram_waddr, 12'h123);
    rst_n = 1'b0;
    #1;
    check("abort_busy_async", bus.clr_busy, 0);
    check("abort_wen_async", bus.ram_wen, 0);
    repeat (2) @(posedge clk);
    sm();
    rst_n = 1'b1;
    check("abort_rready", bus.cpu_rready, 1);
    check("abort_wready", bus.cpu_wready, 1);
    check("abort_wen", bus.ram_wen, 0);
    for (int i = 0; i < 12'h123; i++) ref_mem[i] = 8'h5A;
    cpu_read(12'h122, d, lat);
    check("abort_last_filled", d, ref_mem[12'h122]);
    cpu_read(12'h123, d, lat);
    check("abort_first_unfilled", d, ref_mem[12'h123]);
    vid_read(12'h055);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
